// File: rtl/gbe_rx_conv_pkg.sv
// Shared types and constants for the GbE RX byte-stream to packet-word converter.
package gbe_rx_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int unsigned ERR_CRC = 0;
  localparam int unsigned ERR_PHY = 1;
  localparam int unsigned ERR_LEN = 2;

  localparam logic [15:0] LEN_SAT = 16'hFFFF;

  function automatic int unsigned mod_w(input int unsigned bpw);
    return $clog2(bpw);
  endfunction

endpackage

// File: rtl/gbe_rx_width_conv_byte_packer.sv
// Byte slot counter and word accumulator; places each byte by the configured byte order.
module gbe_rx_byte_packer
  import gbe_rx_conv_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned BPW      = DATA_W / 8,
  localparam int unsigned MOD_W    = mod_w(BPW)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic [MOD_W-1:0]  slot_o,
  output logic              word_full_o
);

  logic [MOD_W-1:0]  slot_q, slot_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  // word_o already contains the incoming byte so the top can register it directly
  always_comb begin
    slot_o = first_i ? '0 : slot_q;
    word_o = first_i ? '0 : acc_q;
    for (int unsigned i = 0; i < BPW; i++) begin
      if (slot_o == MOD_W'(i)) begin
        if (MSB_FIRST) word_o[DATA_W-1-8*i -: 8] = byte_i;
        else           word_o[8*i +: 8]          = byte_i;
      end
    end
    word_full_o = (slot_o == MOD_W'(BPW - 1));

    slot_d = slot_q;
    acc_d  = acc_q;
    if (wr_i) begin
      if (word_full_o || last_i) begin
        slot_d = '0;
        acc_d  = '0;
      end else begin
        slot_d = slot_o + MOD_W'(1);
        acc_d  = word_o;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_q <= '0;
      acc_q  <= '0;
    end else begin
      slot_q <= slot_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/gbe_rx_width_conv.sv
// GbE RX byte stream to packet-word packer with length/error checks and drop-on-full.
// Optional counters enabled by defining GBE_RX_CONV_STATS_EN.
module gbe_rx_width_conv
  import gbe_rx_conv_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 9600,
  localparam int unsigned BPW      = DATA_W / 8,
  localparam int unsigned MOD_W    = mod_w(BPW)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clk_en_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_en_i,
  input  logic              byte_err_i,
  input  logic              byte_end_i,
  input  logic              crc_err_i,
  input  logic              out_full_i,
  output logic [DATA_W-1:0] pkt_data_o,
  output logic              pkt_sop_o,
  output logic              pkt_eop_o,
  output logic [MOD_W-1:0]  pkt_mod_o,
  output logic [15:0]       pkt_len_o,
  output logic [2:0]        pkt_error_o,
  output logic              pkt_val_o
`ifdef GBE_RX_CONV_STATS_EN
  ,
  output logic [31:0]       stat_frames_o,
  output logic [31:0]       stat_drops_o,
  output logic [31:0]       stat_errs_o
`endif
);

  state_e state_q, state_d;
  logic [15:0] len_q, len_d;
  logic        phy_q, phy_d;
  logic        sop_pend_q, sop_pend_d;

  logic              val_q, val_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic [15:0]       len_o_q, len_o_d;
  logic [2:0]        err_q, err_d;

  logic              accept, pk_wr, pk_first, pk_full, emit, eop, drop_evt, len_err;
  logic [DATA_W-1:0] pk_word;
  logic [MOD_W-1:0]  pk_slot;

  assign accept = clk_en_i & byte_en_i;

  gbe_rx_byte_packer #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wr_i        (pk_wr),
    .first_i     (pk_first),
    .last_i      (byte_end_i),
    .byte_i      (byte_data_i),
    .word_o      (pk_word),
    .slot_o      (pk_slot),
    .word_full_o (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    pk_wr      = 1'b0;
    pk_first   = 1'b0;
    emit       = 1'b0;
    eop        = 1'b0;
    drop_evt   = 1'b0;
    len_d      = len_q;
    phy_d      = phy_q;
    sop_pend_d = sop_pend_q;

    unique case (state_q)
      ST_IDLE: if (accept) begin
        // A full downstream only matters at frame start; a 1-byte dropped frame never leaves IDLE
        if (out_full_i) begin
          drop_evt = 1'b1;
          if (!byte_end_i) state_d = ST_DROP;
        end else begin
          pk_wr      = 1'b1;
          pk_first   = 1'b1;
          len_d      = 16'd1;
          phy_d      = byte_err_i;
          sop_pend_d = 1'b1;
          emit       = byte_end_i | pk_full;
          eop        = byte_end_i;
          if (!byte_end_i) state_d = ST_PACK;
        end
      end
      ST_PACK: if (accept) begin
        pk_wr = 1'b1;
        if (len_q != LEN_SAT) len_d = len_q + 16'd1;
        phy_d = phy_q | byte_err_i;
        emit  = byte_end_i | pk_full;
        eop   = byte_end_i;
        if (byte_end_i) state_d = ST_IDLE;
      end
      ST_DROP: if (accept && byte_end_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    len_err = ({16'd0, len_d} < MIN_LEN) || ({16'd0, len_d} > MAX_LEN);

    val_d   = emit;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    mod_d   = mod_q;
    len_o_d = len_o_q;
    err_d   = err_q;
    if (emit) begin
      data_d     = pk_word;
      sop_d      = sop_pend_d;
      eop_d      = eop;
      len_o_d    = len_d;
      mod_d      = eop ? pk_slot + MOD_W'(1) : '0;
      err_d      = '0;
      if (eop) begin
        err_d[ERR_CRC] = crc_err_i;
        err_d[ERR_PHY] = phy_d;
        err_d[ERR_LEN] = len_err;
      end
      sop_pend_d = 1'b0;
    end
    if (eop) phy_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      phy_q      <= 1'b0;
      sop_pend_q <= 1'b0;
      val_q      <= 1'b0;
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      mod_q      <= '0;
      len_o_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      phy_q      <= phy_d;
      sop_pend_q <= sop_pend_d;
      val_q      <= val_d;
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      mod_q      <= mod_d;
      len_o_q    <= len_o_d;
      err_q      <= err_d;
    end
  end

  assign pkt_val_o   = val_q;
  assign pkt_data_o  = data_q;
  assign pkt_sop_o   = sop_q;
  assign pkt_eop_o   = eop_q;
  assign pkt_mod_o   = mod_q;
  assign pkt_len_o   = len_o_q;
  assign pkt_error_o = err_q;

`ifdef GBE_RX_CONV_STATS_EN
  logic [31:0] frames_q, drops_q, errs_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frames_q <= '0;
      drops_q  <= '0;
      errs_q   <= '0;
    end else begin
      if (emit && eop)                 frames_q <= frames_q + 32'd1;
      if (emit && eop && err_d != '0)  errs_q   <= errs_q + 32'd1;
      if (drop_evt)                    drops_q  <= drops_q + 32'd1;
    end
  end

  assign stat_frames_o = frames_q;
  assign stat_drops_o  = drops_q;
  assign stat_errs_o   = errs_q;
`endif

endmodule

// File: tb/tb_gbe_rx_width_conv.sv
// Self-checking bench: 64-bit MSB-first and 32-bit LSB-first converters on a shared byte stream.
module tb_gbe_rx_width_conv;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  mod;
    logic [15:0] len;
    logic [2:0]  err;
  } rec_t;

  typedef struct {
    int len;
    int pat;      // 0 incrementing, 1 random, 2 constant 0xAB
    bit full;
    int err_idx;
    bit crc;
    bit toggle;
    bit gaps;
  } scen_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0, byte_en = 1'b0, byte_err = 1'b0, byte_end = 1'b0;
  logic       crc_err = 1'b0, out_full = 1'b0;
  logic [7:0] byte_data = '0;

  logic [63:0] d64;  logic s64, e64, v64;  logic [2:0] m64;  logic [15:0] l64;  logic [2:0] r64;
  logic [31:0] d32;  logic s32, e32, v32;  logic [1:0] m32;  logic [15:0] l32;  logic [2:0] r32;
`ifdef GBE_RX_CONV_STATS_EN
  logic [31:0] sf64, sd64, se64, sf32, sd32, se32;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  rec_t got64[$];
  rec_t got32[$];
  logic [7:0] frame_q[$];

  always #5 clk = ~clk;

  gbe_rx_width_conv dut (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .byte_data_i(byte_data),
    .byte_en_i(byte_en), .byte_err_i(byte_err), .byte_end_i(byte_end), .crc_err_i(crc_err),
    .out_full_i(out_full), .pkt_data_o(d64), .pkt_sop_o(s64), .pkt_eop_o(e64),
    .pkt_mod_o(m64), .pkt_len_o(l64), .pkt_error_o(r64), .pkt_val_o(v64)
`ifdef GBE_RX_CONV_STATS_EN
    , .stat_frames_o(sf64), .stat_drops_o(sd64), .stat_errs_o(se64)
`endif
  );

  gbe_rx_width_conv #(.DATA_W(32), .MSB_FIRST(1'b0)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .byte_data_i(byte_data),
    .byte_en_i(byte_en), .byte_err_i(byte_err), .byte_end_i(byte_end), .crc_err_i(crc_err),
    .out_full_i(out_full), .pkt_data_o(d32), .pkt_sop_o(s32), .pkt_eop_o(e32),
    .pkt_mod_o(m32), .pkt_len_o(l32), .pkt_error_o(r32), .pkt_val_o(v32)
`ifdef GBE_RX_CONV_STATS_EN
    , .stat_frames_o(sf32), .stat_drops_o(sd32), .stat_errs_o(se32)
`endif
  );

  // Metadata is only meaningful on eop words, so it is zeroed elsewhere before comparison
  always @(negedge clk) begin
    rec_t r;
    if (v64) begin
      r = '0;
      r.data = d64; r.sop = s64; r.eop = e64;
      if (e64) begin r.mod = {1'b0, m64}; r.len = l64; r.err = r64; end
      got64.push_back(r);
    end
    if (v32) begin
      r = '0;
      r.data = {32'd0, d32}; r.sop = s32; r.eop = e32;
      if (e32) begin r.mod = {2'b0, m32}; r.len = l32; r.err = r32; end
      got32.push_back(r);
    end
  end

  function automatic void build_exp(input int unsigned bpw, input bit msb, input bit full,
                                    input int err_idx, input bit crc, output rec_t q[$]);
    int unsigned n, nw;
    n = frame_q.size();
    q = {};
    if (full || n == 0) return;
    nw = (n + bpw - 1) / bpw;
    for (int unsigned w = 0; w < nw; w++) begin
      rec_t r;
      r = '0;
      for (int unsigned k = 0; k < bpw; k++) begin
        if (w * bpw + k < n) begin
          int unsigned sh;
          sh = msb ? (bpw - 1 - k) * 8 : k * 8;
          r.data = r.data | (64'(frame_q[w * bpw + k]) << sh);
        end
      end
      r.sop = (w == 0);
      r.eop = (w == nw - 1);
      if (r.eop) begin
        r.len = (n > 65535) ? 16'hFFFF : 16'(n);
        r.mod = 4'(n % bpw);
        r.err = {(n < 64) || (n > 9600), (err_idx >= 0) && (err_idx < int'(n)), crc};
      end
      q.push_back(r);
    end
  endfunction

  task automatic cyc(input logic en, input logic [7:0] d, input logic be, input logic err,
                     input logic last, input logic crc, input logic full);
    @(posedge clk); #1;
    clk_en = en; byte_data = d; byte_en = be; byte_err = err;
    byte_end = last; crc_err = crc; out_full = full;
  endtask

  task automatic send_frame(input bit full, input int err_idx, input bit crc,
                            input bit toggle, input bit gaps, input bit with_end);
    for (int i = 0; i < frame_q.size(); i++) begin
      logic last;
      if (gaps && $urandom_range(3) == 0)
        cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
      last = with_end && (i == frame_q.size() - 1);
      cyc(1'b1, frame_q[i], 1'b1, i == err_idx, last, crc && last,
          (i == 0) ? full : (gaps ? 1'($urandom) : 1'b0));
      if (toggle)
        cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({v64, d64, s64, e64, m64, l64, r64} !== '0) begin
      n_fail++;
      $display("FAIL reset64: got val=%b data=%h len=%0d err=%b, want all 0", v64, d64, l64, r64);
    end
    n_checks++;
    if ({v32, d32, s32, e32, m32, l32, r32} !== '0) begin
      n_fail++;
      $display("FAIL reset32: got val=%b data=%h len=%0d err=%b, want all 0", v32, d32, l32, r32);
    end
`ifdef GBE_RX_CONV_STATS_EN
    n_checks++;
    if ({sf64, sd64, se64} !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d/%0d, want 0/0/0", sf64, sd64, se64);
    end
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_drop();
    rec_t e[$];
    rec_t g[$];
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    frame_q = {};
    for (int i = 0; i < 64; i++) frame_q.push_back(8'(i));
    got64 = {}; got32 = {};
    send_frame(1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (got64.size() + got32.size() != 0) begin
      n_fail++;
      $display("FAIL drop_full: got %0d+%0d strobes, want 0", got64.size(), got32.size());
    end
    got64 = {}; got32 = {};
    send_frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      build_exp(d ? 4 : 8, d ? 1'b0 : 1'b1, 1'b0, -1, 1'b0, e);
      g = d ? got32 : got64;
      n_checks++;
      if (g.size() != e.size()) begin
        n_fail++;
        $display("FAIL drop_next dut%0d strobes: got %0d want %0d", d, g.size(), e.size());
      end else begin
        foreach (e[i]) begin
          n_checks++;
          if (g[i] !== e[i]) begin
            n_fail++;
            $display("FAIL drop_next dut%0d word%0d: got %h want %h", d, i, g[i], e[i]);
          end
        end
      end
    end
`ifdef GBE_RX_CONV_STATS_EN
    n_checks++;
    if ({sd64, sf64, se64, sd32, sf32} !== {32'd1, 32'd1, 32'd0, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL drop_stats: got drops=%0d frames=%0d errs=%0d drops32=%0d frames32=%0d, want 1 1 0 1 1",
               sd64, sf64, se64, sd32, sf32);
    end
`endif
  endtask

  task automatic test_frames();
    scen_t tbl[$];
    tbl.push_back('{64,   0, 1'b0, -1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{65,   0, 1'b0, -1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{64,   0, 1'b0, 10, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1,    2, 1'b0, -1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{64,   0, 1'b0, -1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{9601, 1, 1'b0, -1, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 30; k++) begin
      scen_t sc;
      sc.len = $urandom_range(150, 1);
      sc.pat = 1;
      sc.full = ($urandom_range(5) == 0);
      sc.err_idx = ($urandom_range(3) == 0) ? int'($urandom_range(sc.len - 1)) : -1;
      sc.crc = 1'($urandom);
      sc.toggle = 1'($urandom);
      sc.gaps = 1'b1;
      tbl.push_back(sc);
    end

    foreach (tbl[s]) begin
      scen_t sc;
      rec_t e[$];
      rec_t g[$];
      sc = tbl[s];
      frame_q = {};
      for (int i = 0; i < sc.len; i++)
        frame_q.push_back(sc.pat == 0 ? 8'(i) : (sc.pat == 1 ? 8'($urandom) : 8'hAB));
      got64 = {}; got32 = {};
      send_frame(sc.full, sc.err_idx, sc.crc, sc.toggle, sc.gaps, 1'b1);
      for (int d = 0; d < 2; d++) begin
        build_exp(d ? 4 : 8, d ? 1'b0 : 1'b1, sc.full, sc.err_idx, sc.crc, e);
        g = d ? got32 : got64;
        n_checks++;
        if (g.size() != e.size()) begin
          n_fail++;
          $display("FAIL frame%0d dut%0d strobes: got %0d want %0d", s, d, g.size(), e.size());
        end else begin
          foreach (e[i]) begin
            n_checks++;
            if (g[i] !== e[i]) begin
              n_fail++;
              $display("FAIL frame%0d dut%0d word%0d: got %h want %h", s, d, i, g[i], e[i]);
            end
          end
        end
      end
      if (s == 0 || s == 4) begin
        n_checks++;
        if (got64.size() != 8 || got64[0].data !== 64'h0001020304050607) begin
          n_fail++;
          $display("FAIL frame%0d word0_64: got n=%0d data=%h want n=8 data=0001020304050607",
                   s, got64.size(), got64.size() ? got64[0].data : 64'd0);
        end
        n_checks++;
        if (got32.size() != 16 || got32[0].data !== 64'h03020100 || got32[15].mod !== 4'd0) begin
          n_fail++;
          $display("FAIL frame%0d word0_32: got n=%0d data=%h want n=16 data=03020100 mod=0",
                   s, got32.size(), got32.size() ? got32[0].data : 64'd0);
        end
      end
      if (s == 1) begin
        n_checks++;
        if (got64.size() != 9 || {got64[8].data, got64[8].mod, got64[8].len} !==
            {64'h4000000000000000, 4'd1, 16'd65}) begin
          n_fail++;
          $display("FAIL frame65_last: got n=%0d want n=9 data=4000000000000000 mod=1 len=65",
                   got64.size());
        end
      end
      if (s == 2) begin
        n_checks++;
        if (got64.size() == 0 || got64[$].err !== 3'b011) begin
          n_fail++;
          $display("FAIL crc_phy_err: got %b want 011", got64.size() ? got64[$].err : 3'b000);
        end
      end
      if (s == 3) begin
        n_checks++;
        if (got64.size() != 1 || got64[0] !== {64'hAB00000000000000, 1'b1, 1'b1, 4'd1, 16'd1, 3'b100}) begin
          n_fail++;
          $display("FAIL single_byte: got n=%0d rec=%h want one rec data=AB00000000000000 sop eop mod=1 len=1 err=100",
                   got64.size(), got64.size() ? got64[0] : '0);
        end
      end
      if (s == 5) begin
        n_checks++;
        if (got64.size() == 0 || {got64[$].len, got64[$].err} !== {16'd9601, 3'b100}) begin
          n_fail++;
          $display("FAIL max_len: got len=%0d err=%b want 9601 100",
                   got64.size() ? got64[$].len : 16'd0, got64.size() ? got64[$].err : 3'b000);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    rec_t e[$];
    rec_t g[$];
    frame_q = {};
    for (int i = 0; i <= 20; i++) frame_q.push_back(8'(i));
    send_frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({v64, d64, s64, e64, m64, l64, r64, v32, d32, s32, e32, m32, l32, r32} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got data64=%h len64=%0d data32=%h, want all 0", d64, l64, d32);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    got64 = {}; got32 = {};
    frame_q = {};
    for (int i = 21; i < 64; i++) frame_q.push_back(8'(i));
    send_frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      build_exp(d ? 4 : 8, d ? 1'b0 : 1'b1, 1'b0, -1, 1'b0, e);
      g = d ? got32 : got64;
      n_checks++;
      if (g.size() != e.size()) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d strobes: got %0d want %0d", d, g.size(), e.size());
      end else begin
        foreach (e[i]) begin
          n_checks++;
          if (g[i] !== e[i]) begin
            n_fail++;
            $display("FAIL reset_mid dut%0d word%0d: got %h want %h", d, i, g[i], e[i]);
          end
        end
      end
    end
    n_checks++;
    if (got64.size() == 0 || {got64[$].len, got64[$].err} !== {16'd43, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_mid_len: got len=%0d err=%b want 43 100",
               got64.size() ? got64[$].len : 16'd0, got64.size() ? got64[$].err : 3'b000);
    end
  endtask

  initial begin
    test_reset();
    test_drop();
    test_frames();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
